unified_sram_arbiter: RTL

//  Shares one single-port 64-bit SRAM between the core's instruction-fetch port (32-bit read-only)
//  and data port (64-bit read/write, byte-enabled). Sits between the core and the unified memory
//  in the simulation top. Grants at most one access per cycle and returns responses one cycle later.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/arb_perf_counters.sv | 35 +++
 rtl/unified_sram_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the unified SRAM arbiter.
package arb_pkg;

  localparam int MEM_AW   = 32;
  localparam int MEM_DW   = 64;
  localparam int INST_DW  = 32;
  localparam int MEM_BE_W = 8;

  // Which requester owns the response arriving from the SRAM this cycle.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_INST = 2'd1,
    RSP_DATA = 2'd2
  } rsp_src_e;

  // The SRAM is 64 bits wide, so the three low address bits never reach it.
  function automatic logic [MEM_AW-1:0] line_addr(input logic [MEM_AW-1:0] a);
    return {a[MEM_AW-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// Grant / stall performance counters for the unified SRAM arbiter.
// Instantiated only when ARB_PERF_EN is defined. Counters wrap modulo 2^CNT_W.
module arb_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_gnt,
  input  logic             d_gnt,
  input  logic             i_stall,
  output logic [CNT_W-1:0] perf_i_gnt,
  output logic [CNT_W-1:0] perf_d_gnt,
  output logic [CNT_W-1:0] perf_i_stall
);

  logic [CNT_W-1:0] i_gnt_q, d_gnt_q, i_stall_q;

  // Count grant and stall cycles; cleared while reset is low.
  always_ff @(posedge clock) begin
    if (!reset) begin
      i_gnt_q   <= '0;
      d_gnt_q   <= '0;
      i_stall_q <= '0;
    end else begin
      i_gnt_q   <= i_gnt_q + CNT_W'(i_gnt);
      d_gnt_q   <= d_gnt_q + CNT_W'(d_gnt);
      i_stall_q <= i_stall_q + CNT_W'(i_stall);
    end
  end

  assign perf_i_gnt   = i_gnt_q;
  assign perf_d_gnt   = d_gnt_q;
  assign perf_i_stall = i_stall_q;

endmodule

// File: rtl/unified_sram_arbiter.sv
// Unified SRAM arbiter: shares one single-port 64-bit SRAM between a 32-bit
// read-only instruction-fetch port and a 64-bit byte-enabled data port.
// Data wins by default; a saturating starvation counter forces one fetch
// through after STARVE_LIMIT consecutive losses. Responses return exactly one
// cycle after the grant.
// Optional feature macro: ARB_PERF_EN adds grant/stall performance counters.
module unified_sram_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [MEM_AW-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [INST_DW-1:0]    i_rdata,
  input  logic                  d_req,
  input  logic [MEM_BE_W-1:0]   d_wen,
  input  logic [MEM_AW-1:0]     d_addr,
  input  logic [MEM_DW-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [MEM_DW-1:0]     d_rdata,
  output logic                  mem_en,
  output logic [MEM_BE_W-1:0]   mem_wen,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [MEM_DW-1:0]     mem_wdata,
  input  logic [MEM_DW-1:0]     mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_i_gnt,
  output logic [CNT_W-1:0]      perf_d_gnt,
  output logic [CNT_W-1:0]      perf_i_stall
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  rsp_src_e      rsp_src_q;
  logic          rsp_hi_q;
  logic          inst_forced;
  logic          unused_addr_bits;

  // Address bits below the SRAM word (and below the fetch half-word) carry no meaning.
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[2:0]};

  // Grant decision: data first unless the fetch port has hit its starvation limit.
  always_comb begin
    inst_forced = i_req && (starve_q == SW'(STARVE_LIMIT));
    d_gnt       = reset && d_req && !inst_forced;
    i_gnt       = reset && i_req && !d_gnt;
  end

  // Steer the granted requester onto the SRAM port; idle port drives zeros.
  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_wen   = d_wen;
      mem_addr  = line_addr(d_addr);
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = line_addr(i_addr);
    end
  end

  // Next starvation count: cleared once the fetch is served or withdrawn, saturating otherwise.
  always_comb begin
    starve_d = starve_q;
    if (i_gnt || !i_req) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Register starvation count and response ownership; reset drops any in-flight response.
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_q  <= '0;
      rsp_src_q <= RSP_NONE;
    end else begin
      starve_q  <= starve_d;
      rsp_src_q <= i_gnt ? RSP_INST : (d_gnt ? RSP_DATA : RSP_NONE);
    end
  end

  // Remember which 32-bit half of the SRAM word the granted fetch wants.
  always_ff @(posedge clock) begin
    if (i_gnt) begin
      rsp_hi_q <= i_addr[2];
    end
  end

  // Response routing; outputs are held at zero while reset is low or no response is due.
  assign i_rvalid = reset && (rsp_src_q == RSP_INST);
  assign d_rvalid = reset && (rsp_src_q == RSP_DATA);
  assign i_rdata  = i_rvalid ? (rsp_hi_q ? mem_rdata[63:32] : mem_rdata[31:0]) : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_EN
  arb_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clock       (clock),
    .reset       (reset),
    .i_gnt       (i_gnt),
    .d_gnt       (d_gnt),
    .i_stall     (i_req && !i_gnt),
    .perf_i_gnt  (perf_i_gnt),
    .perf_d_gnt  (perf_d_gnt),
    .perf_i_stall(perf_i_stall)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
